// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state encoding and counter sizing.
package ex_muldiv_pkg;

  localparam int MD_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Iteration counter width; floor of 1 keeps tiny widths from collapsing to 0 bits.
  function automatic int md_cnt_bits(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int MD_CNT_W = md_cnt_bits(MD_WIDTH_DEF);

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Even encodings (MULT, DIV, MADD, MSUB) are the signed variants.
  function automatic logic md_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module ex_div_step
  #(parameter int WIDTH = 32)
  (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dbit,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
  );

  logic [WIDTH:0] partial;

  assign partial = {rem, dbit};
  assign qbit    = (partial >= {1'b0, divisor});

  // rem < divisor on entry, so partial - divisor always fits in WIDTH bits.
  assign rem_next = qbit ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for EX with HI/LO result and done pulse.
// Accumulating ops (MADD/MSUB family) exist only when EX_MULDIV_ACC_EN is defined.
module ex_muldiv
  import ex_muldiv_pkg::*;
  #(parameter int WIDTH = 32)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic             annul,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
  );

  localparam int              CNT_W    = md_cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  // Multiply: {partial high, multiplier shifting out}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opnd;
  logic               res_neg;
  logic               rem_neg;
  logic               dz;

  logic               op_legal;
  logic               op_div;
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] fix_res;

`ifdef EX_MULDIV_ACC_EN
  logic [2*WIDTH-1:0] acc_q;
  assign op_legal = 1'b1;
`else
  logic acc_unused;
  assign acc_unused = ^{acc_hi, acc_lo};
  assign op_legal   = ~op[2];
`endif

  assign op_div    = md_is_div(op);
  assign op_signed = md_is_signed(op);
  assign a_mag     = (op_signed && opa[WIDTH-1]) ? -opa : opa;
  assign b_mag     = (op_signed && opb[WIDTH-1]) ? -opb : opb;
  assign state_dbg = state;

  // Shift-add multiply step: conditionally add multiplicand, then shift right.
  assign mul_add  = prod[0] ? opnd : '0;
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
  assign mul_next = {mul_sum, prod[WIDTH-1:1]};

  ex_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (prod[2*WIDTH-1:WIDTH]),
    .divisor  (opnd),
    .dbit     (prod[WIDTH-1]),
    .rem_next (step_rem),
    .qbit     (step_q)
  );

  assign div_next = {step_rem, prod[WIDTH-2:0], step_q};

  always_comb begin
    mul_res = res_neg ? -prod : prod;
    quo_fix = res_neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem_fix = rem_neg ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    fix_res = mul_res;
    if (dz) begin
      fix_res = prod;
    end else if (md_is_div(op_q)) begin
      fix_res = {rem_fix, quo_fix};
`ifdef EX_MULDIV_ACC_EN
    end else if (op_q[2]) begin
      fix_res = op_q[1] ? (acc_q - mul_res) : (acc_q + mul_res);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      prod        <= '0;
      opnd        <= '0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
`ifdef EX_MULDIV_ACC_EN
      acc_q       <= '0;
`endif
    end else if (annul) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          if (start && op_legal) begin
            op_q    <= op;
            cnt     <= '0;
            busy    <= 1'b1;
            res_neg <= op_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            rem_neg <= op_signed & opa[WIDTH-1];
`ifdef EX_MULDIV_ACC_EN
            acc_q   <= {acc_hi, acc_lo};
`endif
            if (op_div) begin
              opnd <= b_mag;
              if (opb == '0) begin
                // Divide by zero skips iteration; FIX passes prod through as {opa, ones}.
                dz    <= 1'b1;
                prod  <= {opa, {WIDTH{1'b1}}};
                state <= ST_FIX;
              end else begin
                dz    <= 1'b0;
                prod  <= {{WIDTH{1'b0}}, a_mag};
                state <= ST_CALC;
              end
            end else begin
              dz    <= 1'b0;
              opnd  <= a_mag;
              prod  <= {{WIDTH{1'b0}}, b_mag};
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          prod <= md_is_div(op_q) ? div_next : mul_next;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          hi_out      <= fix_res[2*WIDTH-1:WIDTH];
          lo_out      <= fix_res[WIDTH-1:0];
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed and random ops against an arithmetic reference
// model, with annul, mid-operation reset and illegal-op handling.
module tb_ex_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic [W-1:0] acc_hi;
  logic [W-1:0] acc_lo;
  logic         annul;
  logic         busy;
  logic         done;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];

  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .acc_hi      (acc_hi),
    .acc_lo      (acc_lo),
    .annul       (annul),
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] ah,
                                         input logic [W-1:0] al);
    longint       sa;
    longint       sb;
    logic [63:0]  sp;
    logic [63:0]  up;
    logic [63:0]  acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sp  = 64'(sa * sb);
    up  = {32'b0, a} * {32'b0, b};
    acc = {ah, al};
    case (o)
      3'd0: return {1'b0, sp};
      3'd1: return {1'b0, up};
      3'd2: begin
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        return {1'b0, a % b, a / b};
      end
      3'd4: return {1'b0, acc + sp};
      3'd5: return {1'b0, acc + up};
      3'd6: return {1'b0, acc - sp};
      default: return {1'b0, acc - up};
    endcase
  endfunction

  // driver: waits for IDLE, pulses start for one cycle; optionally records expectation
  task automatic start_only(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ah, input logic [W-1:0] al, input bit push);
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_wait_timeout", 64'd1, 64'd0);
    op = o; opa = a; opb = b; acc_hi = ah; acc_lo = al;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(model(o, a, b, ah, al));
      exp_cyc_q.push_back(cyc + ((o[2:1] == 2'b01 && b == 0) ? 2 : W + 2));
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ah, input logic [W-1:0] al);
    int n = 0;
    start_only(o, a, b, ah, al, 1'b1);
    check("busy_cycle1", busy, 64'd1);
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("done_timeout", 64'd1, 64'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // scoreboard: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        logic [2*W:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("hi", hi_out, e[2*W-1:W]);
        check("lo", lo_out, e[W-1:0]);
        check("div_by_zero", div_by_zero, e[2*W]);
        check("done_cycle", cyc, ec);
        check("busy_at_done", busy, 64'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; annul = 1'b0; op = '0;
    opa = '0; opb = '0; acc_hi = '0; acc_lo = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_hi", hi_out, 64'd0);
    check("rst_lo", lo_out, 64'd0);
    check("rst_dz", div_by_zero, 64'd0);
    check("rst_state", state_dbg, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, '0, '0);
    check("mult_hi", hi_out, 64'hFFFF_FFFF);
    check("mult_lo", lo_out, 64'hFFFF_FFFA);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, '0, '0);
    check("div_lo", lo_out, 64'hFFFF_FFFD);
    check("div_hi", hi_out, 64'hFFFF_FFFF);
    do_op(3'd3, 32'd7, 32'd2, '0, '0);
    check("divu_lo", lo_out, 64'd3);
    check("divu_hi", hi_out, 64'd1);
    do_op(3'd3, 32'h1234, 32'd0, '0, '0);
    check("dz_hi", hi_out, 64'h1234);
    check("dz_lo", lo_out, 64'hFFFF_FFFF);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0);
    check("minneg_lo", lo_out, 64'h8000_0000);
    check("minneg_hi", hi_out, 64'd0);
    do_op(3'd2, 32'hFFFF_FF00, 32'd0, '0, '0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0);

    // annul in cycle 10 of a MULT
    prev_hi = hi_out;
    prev_lo = lo_out;
    start_only(3'd0, 32'd123, 32'd456, '0, '0, 1'b0);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    check("annul_busy", busy, 64'd0);
    check("annul_state", state_dbg, 64'd0);
    check("annul_hi", hi_out, prev_hi);
    check("annul_lo", lo_out, prev_lo);
    do_op(3'd0, 32'd1000, 32'hFFFF_FFF6, '0, '0);

    // annul together with start in IDLE drops the request
    annul = 1'b1;
    start_only(3'd1, 32'd5, 32'd6, '0, '0, 1'b0);
    annul = 1'b0;
    check("annul_start_busy", busy, 64'd0);

`ifdef EX_MULDIV_ACC_EN
    do_op(3'd4, 32'd4, 32'hFFFF_FFFF, 32'd0, 32'd5);
    check("madd_hi", hi_out, 64'd0);
    check("madd_lo", lo_out, 64'd1);
    do_op(3'd6, 32'd3, 32'd3, 32'd0, 32'd2);
    do_op(3'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd7, 32'd9, 32'd9, 32'd1, 32'd0);
`else
    prev_hi = hi_out;
    prev_lo = lo_out;
    start_only(3'd4, 32'd4, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0);
    check("madd_illegal_busy", busy, 64'd0);
    start_only(3'd7, 32'd4, 32'd4, 32'd0, 32'd5, 1'b0);
    check("msubu_illegal_busy", busy, 64'd0);
    repeat (40) @(negedge clk);
    check("illegal_state", state_dbg, 64'd0);
    check("illegal_hi", hi_out, prev_hi);
    check("illegal_lo", lo_out, prev_lo);
`endif

    // reset in cycle 15 of a DIV
    start_only(3'd2, 32'd1000, 32'd7, '0, '0, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 64'd0);
    check("midrst_done", done, 64'd0);
    check("midrst_hi", hi_out, 64'd0);
    check("midrst_lo", lo_out, 64'd0);
    check("midrst_state", state_dbg, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(3'd2, 32'd1000, 32'd7, '0, '0);
    check("postrst_lo", lo_out, 64'd142);
    check("postrst_hi", hi_out, 64'd6);

    // random back-to-back traffic
    for (int i = 0; i < 24; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
`ifdef EX_MULDIV_ACC_EN
      o = 3'($urandom_range(0, 7));
`else
      o = 3'($urandom_range(0, 3));
`endif
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      do_op(o, a, b, $urandom, $urandom);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
